bus_dev_endpoint: RTL and testbench
===================================

BUS_DEV_ENDPOINT -- requirements
Module: bus_dev_endpoint

Interface
REQ-001 The block SHALL have parameter pckg_sz, default 16: packet width in bits; bits [pckg_sz-1:pckg_sz-8] carry the destination ID.
REQ-002 The block SHALL have parameter depth, default 8: entries in each of the TX and RX FIFOs; must be a power of two and at least 2.
REQ-003 The block SHALL have parameter id, default 0: this endpoint's 8-bit port ID.
REQ-004 The block SHALL have parameter broadcast, default {8{1'b1}}: destination ID accepted by every endpoint.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have the port wr_en, input, 1 bit: local request to enqueue a packet for transmission.
REQ-008 The block SHALL have the port wr_data, input, pckg_sz bits: the local packet to enqueue.
REQ-009 The block SHALL have the port tx_full, output, 1 bit: the TX FIFO holds depth entries.
REQ-010 The block SHALL have the port pndng, output, 1 bit: the TX FIFO is non-empty (pending toward the bus).
REQ-011 The block SHALL have the port D_pop, output, pckg_sz bits: the TX FIFO head, shown first-word-fall-through.
REQ-012 The block SHALL have the port pop, input, 1 bit: the bus arbiter consumes the TX head.
REQ-013 The block SHALL have the port push, input, 1 bit: the bus arbiter delivers a packet.
REQ-014 The block SHALL have the port D_push, input, pckg_sz bits: the delivered packet.
REQ-015 The block SHALL have the port rd_en, input, 1 bit: local request to dequeue the RX head.
REQ-016 The block SHALL have the port rd_data, output, pckg_sz bits: the RX FIFO head, first-word-fall-through.
REQ-017 The block SHALL have the port rx_empty, output, 1 bit: the RX FIFO holds no entries.
REQ-018 The block SHALL have the port rx_count, output, $clog2(depth+1) bits: the RX occupancy.
REQ-019 The block SHALL have the port tx_ovf, output, 1 bit: sticky flag set when a write is lost because the TX FIFO is full.
REQ-020 The block SHALL have the port rx_drop_cnt, output, 8 bits: saturating count of addressed packets lost because the RX FIFO is full.
REQ-021 The block SHALL have the port mis_cnt, output, 8 bits: saturating count of pushes whose destination is neither id nor broadcast.

Function
REQ-022 A wr_en with tx_full=0 SHALL enqueue wr_data; pndng SHALL rise on the next clock edge when the FIFO was empty.
REQ-023 A wr_en with tx_full=1 SHALL drop the data and set tx_ovf, including when pop is asserted in the same cycle.
REQ-024 pop with pndng=1 SHALL advance the TX head at the clock edge, so D_pop shows the next entry in the following cycle.
REQ-025 pop with pndng=0 SHALL be ignored.
REQ-026 Simultaneous wr_en and pop on a non-full, non-empty TX FIFO SHALL leave the occupancy unchanged.
REQ-027 Simultaneous wr_en and pop on an empty TX FIFO SHALL enqueue the write and ignore the pop.
REQ-028 A push SHALL be accepted only when D_push[pckg_sz-1:pckg_sz-8] equals id or broadcast.
REQ-029 An accepted push with rx_count<depth SHALL enqueue D_push, with a visible effect on rx_count and rd_data on the next edge.
REQ-030 An accepted push with rx_count==depth SHALL drop the packet and increment rx_drop_cnt, even if rd_en is asserted in the same cycle.
REQ-031 A non-matching push SHALL leave the RX FIFO unchanged and increment mis_cnt.
REQ-032 rx_drop_cnt and mis_cnt SHALL saturate at 255.
REQ-033 rd_en with rx_empty=1 SHALL be ignored.
REQ-034 Simultaneous rd_en and accepted push on a non-empty, non-full RX FIFO SHALL keep rx_count unchanged.
REQ-035 Pointers SHALL wrap modulo depth; occupancy SHALL be tracked with a counter, not pointer comparison alone.

Reset
REQ-036 While reset=0, asynchronously, both FIFOs SHALL empty and all counters and flags SHALL clear: pndng=0, tx_full=0, rx_empty=1, rx_count=0, tx_ovf=0, rx_drop_cnt=0, mis_cnt=0.
REQ-037 While reset=0, D_pop and rd_data SHALL be 0.
REQ-038 A reset asserted mid-operation SHALL discard all queued packets; no pop, push, wr_en or rd_en SHALL take effect while reset=0.

Structure
REQ-039 The ID width (8), the default broadcast ID and the ID-extraction function SHALL live in the shared bus package.
REQ-040 The block SHALL instantiate sub-module sync_fifo (parameters width and depth; FWFT; with count, full and empty outputs) twice, once for TX and once for RX.

Verification
REQ-041 The bench SHALL write 0x0A11, 0x0B22, 0x0C33, then pop three times -> D_pop shows 0x0A11, 0x0B22, 0x0C33 in order; pndng falls after the third pop.
REQ-042 The bench SHALL write 9 packets with depth=8 and no pop -> tx_full=1 after the 8th write; tx_ovf=1; the 9th packet is never seen on D_pop.
REQ-043 With id=3, the bench SHALL push 0x0312, 0xFF34 and 0x0556 -> rx_count=2; rd_data shows 0x0312, then 0xFF34; mis_cnt=1.
REQ-044 The bench SHALL fill the RX FIFO with 8 packets addressed to id, then push a 9th with rd_en asserted -> the 9th is dropped and rx_drop_cnt=1.
REQ-045 The bench SHALL issue 300 non-matching pushes -> mis_cnt=255.
REQ-046 The bench SHALL queue 4 TX and 4 RX packets, then pulse reset low between clock edges -> pndng=0, rx_empty=1 and all counters 0 immediately; a new packet 0x0001 written after reset appears on D_pop.

Source files
------------

// File: rtl/bus_dev_endpoint_pkg.sv
// Shared bus definitions: endpoint ID width, broadcast ID and destination extraction.
package bus_dev_endpoint_pkg;
  localparam int ID_W      = 8;
  localparam int MAX_PKT_W = 256;
  localparam logic [ID_W-1:0] BCAST_ID = {ID_W{1'b1}};

  // Destination ID sits in the top ID_W bits of a pkt_w-wide packet.
  function automatic logic [ID_W-1:0] dest_id(input logic [MAX_PKT_W-1:0] pkt,
                                              input int unsigned pkt_w);
    logic [MAX_PKT_W-1:0] sh;
    sh = pkt >> (pkt_w - ID_W);
    return sh[ID_W-1:0];
  endfunction
endpackage

// File: rtl/bus_dev_endpoint_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy counter.
// Writes are refused when full even if a read happens in the same cycle.
module sync_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [width-1:0]           wdata,
  input  logic                       rd,
  output logic [width-1:0]           rdata,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CW'(depth));
  assign empty = (count == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bus_dev_endpoint.sv
// Bus endpoint: TX queue toward the arbiter, address-filtered RX queue from it,
// plus overflow/drop/misroute status.
module bus_dev_endpoint
  import bus_dev_endpoint_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              depth     = 8,
  parameter logic [ID_W-1:0] id        = '0,
  parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       tx_full,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rd_en,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rx_empty,
  output logic [$clog2(depth+1)-1:0] rx_count,
  output logic                       tx_ovf,
  output logic [7:0]                 rx_drop_cnt,
  output logic [7:0]                 mis_cnt
);
  localparam int CW = $clog2(depth+1);

  logic [CW-1:0]        tx_count;
  logic                 tx_empty;
  logic                 rx_full;
  logic [MAX_PKT_W-1:0] push_ext;
  logic [ID_W-1:0]      push_dest;
  logic                 push_match;
  logic                 rx_wr;

  assign pndng = !tx_empty;

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr_en),
    .wdata (wr_data),
    .rd    (pop),
    .rdata (D_pop),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign push_ext   = MAX_PKT_W'(D_push);
  assign push_dest  = dest_id(push_ext, pckg_sz);
  assign push_match = (push_dest == id) || (push_dest == broadcast);
  assign rx_wr      = push && push_match;

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_wr),
    .wdata (D_push),
    .rd    (rd_en),
    .rdata (rd_data),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // A full FIFO refuses writes even when drained in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf      <= 1'b0;
      rx_drop_cnt <= '0;
      mis_cnt     <= '0;
    end else begin
      if (wr_en && (tx_count == CW'(depth))) tx_ovf <= 1'b1;
      if (rx_wr && rx_full && (rx_drop_cnt != 8'hFF))
        rx_drop_cnt <= rx_drop_cnt + 8'd1;
      if (push && !push_match && (mis_cnt != 8'hFF))
        mis_cnt <= mis_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Bench for bus_dev_endpoint: directed scenarios plus random traffic vs a queue model.
module tb_bus_dev_endpoint;
  localparam int PW = 16;
  localparam int DEPTH = 8;
  localparam logic [7:0] MY_ID = 8'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, pop, push, rd_en;
  logic [PW-1:0] wr_data, D_push;
  logic          tx_full, pndng, rx_empty, tx_ovf;
  logic [PW-1:0] D_pop, rd_data;
  logic [3:0]    rx_count;
  logic [7:0]    rx_drop_cnt, mis_cnt;

  int total = 0;
  int bad = 0;

  logic [PW-1:0] tx_q[$];
  logic [PW-1:0] rx_q[$];
  bit            m_ovf;
  int            m_drop, m_mis;

  bus_dev_endpoint #(.pckg_sz(PW), .depth(DEPTH), .id(MY_ID), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .tx_ovf(tx_ovf), .rx_drop_cnt(rx_drop_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pndng", 32'(pndng), 32'(tx_q.size() != 0));
    chk("tx_full", 32'(tx_full), 32'(tx_q.size() == DEPTH));
    chk("D_pop", 32'(D_pop), (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'd0);
    chk("rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
    chk("rx_count", 32'(rx_count), 32'(rx_q.size()));
    chk("rd_data", 32'(rd_data), (rx_q.size() != 0) ? 32'(rx_q[0]) : 32'd0);
    chk("tx_ovf", 32'(tx_ovf), 32'(m_ovf));
    chk("rx_drop_cnt", 32'(rx_drop_cnt), 32'(m_drop));
    chk("mis_cnt", 32'(mis_cnt), 32'(m_mis));
  endtask

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    m_ovf = 0;
    m_drop = 0;
    m_mis = 0;
  endtask

  // One clock with the given inputs; the model advances from its pre-edge state.
  task automatic cycle(input bit we, input logic [PW-1:0] wd, input bit p,
                       input bit ps, input logic [PW-1:0] dp, input bit re);
    bit tx_room, tx_has, rx_room, rx_has, addressed;
    wr_en = we; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = re;
    tx_room = tx_q.size() < DEPTH;
    tx_has  = tx_q.size() > 0;
    rx_room = rx_q.size() < DEPTH;
    rx_has  = rx_q.size() > 0;
    addressed = (dp[15:8] == MY_ID) || (dp[15:8] == 8'hFF);
    if (we && !tx_room) m_ovf = 1;
    if (p && tx_has) void'(tx_q.pop_front());
    if (we && tx_room) tx_q.push_back(wd);
    if (ps && !addressed && m_mis < 255) m_mis++;
    if (ps && addressed && !rx_room && m_drop < 255) m_drop++;
    if (re && rx_has) void'(rx_q.pop_front());
    if (ps && addressed && rx_room) rx_q.push_back(dp);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    wr_en = 0; pop = 0; push = 0; rd_en = 0; wr_data = '0; D_push = '0;
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    wr_en = 0; pop = 0; push = 0; rd_en = 0; wr_data = '0; D_push = '0;
    model_clear();
    #2;
    check_all();
    do_reset();

    // In-order TX drain
    cycle(1, 16'h0A11, 0, 0, '0, 0);
    chk("d41_pndng", 32'(pndng), 32'd1);
    cycle(1, 16'h0B22, 0, 0, '0, 0);
    cycle(1, 16'h0C33, 0, 0, '0, 0);
    chk("d41_head0", 32'(D_pop), 32'h0A11);
    cycle(0, '0, 1, 0, '0, 0);
    chk("d41_head1", 32'(D_pop), 32'h0B22);
    cycle(0, '0, 1, 0, '0, 0);
    chk("d41_head2", 32'(D_pop), 32'h0C33);
    cycle(0, '0, 1, 0, '0, 0);
    chk("d41_pndng_low", 32'(pndng), 32'd0);
    cycle(1, 16'h0D44, 1, 0, '0, 0);
    chk("empty_wr_pop", 32'(D_pop), 32'h0D44);

    // TX overflow, including write+pop on a full FIFO
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(1, 16'h1000 + 16'(i), 0, 0, '0, 0);
      if (i == 7) chk("d42_full8", 32'(tx_full), 32'd1);
    end
    chk("d42_ovf", 32'(tx_ovf), 32'd1);
    cycle(1, 16'h2222, 1, 0, '0, 0);
    chk("full_wr_pop_cnt", 32'(tx_full), 32'd0);
    for (int i = 1; i < 8; i++) begin
      chk("d42_order", 32'(D_pop), 32'h1000 + 32'(i));
      cycle(0, '0, 1, 0, '0, 0);
    end
    chk("d42_pndng_low", 32'(pndng), 32'd0);

    // RX address filtering
    do_reset();
    cycle(0, '0, 0, 1, 16'h0312, 0);
    cycle(0, '0, 0, 1, 16'hFF34, 0);
    cycle(0, '0, 0, 1, 16'h0556, 0);
    chk("d43_count", 32'(rx_count), 32'd2);
    chk("d43_head0", 32'(rd_data), 32'h0312);
    chk("d43_mis", 32'(mis_cnt), 32'd1);
    cycle(0, '0, 0, 1, 16'h0377, 1);
    chk("d43_head1", 32'(rd_data), 32'hFF34);
    chk("rd_push_count", 32'(rx_count), 32'd2);

    // RX full drop with simultaneous read
    do_reset();
    for (int i = 0; i < 8; i++) cycle(0, '0, 0, 1, 16'h0300 + 16'(i), 0);
    chk("d44_full", 32'(rx_count), 32'd8);
    cycle(0, '0, 0, 1, 16'h03EE, 1);
    chk("d44_drop", 32'(rx_drop_cnt), 32'd1);
    chk("d44_count", 32'(rx_count), 32'd7);
    cycle(0, '0, 0, 0, '0, 1);
    chk("d44_no9th", 32'(rd_data), 32'h0302);

    // Misroute counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) cycle(0, '0, 0, 1, 16'h7700 + 16'(i & 255), 0);
    chk("d45_mis_sat", 32'(mis_cnt), 32'd255);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [PW-1:0] dp;
      logic [7:0] dst;
      int sel;
      sel = int'($urandom_range(0, 3));
      dst = (sel == 0) ? MY_ID : (sel == 1) ? 8'hFF : 8'($urandom);
      dp = {dst, 8'($urandom)};
      cycle(($urandom_range(0, 9) < 4), 16'($urandom), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) < 5), dp, ($urandom_range(0, 9) < 3));
    end

    // Mid-operation async reset
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle(1, 16'h5000 + 16'(i), 0, 1, 16'h0360 + 16'(i), 0);
    #2;
    reset = 1'b0;
    wr_en = 1; wr_data = 16'hBEEF; push = 1; D_push = 16'h0399; pop = 1; rd_en = 1;
    model_clear();
    #1;
    chk("d46_pndng", 32'(pndng), 32'd0);
    chk("d46_rx_empty", 32'(rx_empty), 32'd1);
    chk("d46_rx_count", 32'(rx_count), 32'd0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    wr_en = 0; push = 0; pop = 0; rd_en = 0;
    reset = 1'b1;
    cycle(1, 16'h0001, 0, 0, '0, 0);
    chk("d46_new", 32'(D_pop), 32'h0001);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
